// File: rtl/sound_event_sequencer.sv
// sound_event_sequencer: turns single-cycle game events into timed beep
// envelopes (one eat beep, or a multi-beep crash pattern) for the tone stage.
module sound_event_sequencer #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int EAT_MS       = 80,
  parameter int CRASH_ON_MS  = 200,
  parameter int CRASH_OFF_MS = 150,
  parameter int CRASH_BEEPS  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eat_evt,
  input  logic crash_evt,
  input  logic mute,
  output logic alarm,
  output logic busy,
  output logic crash_active
);

  localparam int TICKS_PER_MS = CLK_HZ / 1000;
  // Keep the cycle counter at least one bit wide even when a millisecond is a single cycle.
  localparam int CYC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICKS_PER_MS - 1);
  localparam logic [15:0] EAT_LAST       = 16'(EAT_MS - 1);
  localparam logic [15:0] CRASH_ON_LAST  = 16'(CRASH_ON_MS - 1);
  localparam logic [15:0] CRASH_OFF_LAST = 16'(CRASH_OFF_MS - 1);
  localparam logic [3:0]  BEEPS          = 4'(CRASH_BEEPS);

  typedef enum logic [1:0] {
    IDLE,
    EAT_ON,
    CRASH_ON,
    CRASH_OFF
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_cnt_q;
  logic [15:0]      ms_cnt_q;
  logic [3:0]       beep_idx_q, beep_idx_d;
  logic             restart;
  logic [15:0]      phase_last;
  logic             phase_done;

  // Length of the current phase (last ms index) and its expiry on the final cycle.
  always_comb begin
    phase_last = 16'd0;
    case (state_q)
      EAT_ON:    phase_last = EAT_LAST;
      CRASH_ON:  phase_last = CRASH_ON_LAST;
      CRASH_OFF: phase_last = CRASH_OFF_LAST;
      default:   phase_last = 16'd0;
    endcase
    phase_done = (cyc_cnt_q == CYC_LAST) && (ms_cnt_q == phase_last);
  end

  // Next-state decode; restart marks every state entry so the phase timer clears.
  always_comb begin
    state_d    = state_q;
    beep_idx_d = beep_idx_q;
    restart    = 1'b0;
    case (state_q)
      IDLE: begin
        if (crash_evt) begin
          state_d    = CRASH_ON;
          beep_idx_d = 4'd1;
          restart    = 1'b1;
        end else if (eat_evt) begin
          state_d = EAT_ON;
          restart = 1'b1;
        end
      end
      EAT_ON: begin
        if (crash_evt) begin
          state_d    = CRASH_ON;
          beep_idx_d = 4'd1;
          restart    = 1'b1;
        end else if (eat_evt) begin
          state_d = EAT_ON;
          restart = 1'b1;
        end else if (phase_done) begin
          state_d = IDLE;
          restart = 1'b1;
        end
      end
      // Events are deliberately ignored for the whole crash pattern.
      CRASH_ON: begin
        if (phase_done) begin
          restart = 1'b1;
          if (beep_idx_q == BEEPS) begin
            state_d    = IDLE;
            beep_idx_d = 4'd0;
          end else begin
            state_d = CRASH_OFF;
          end
        end
      end
      CRASH_OFF: begin
        if (phase_done) begin
          state_d    = CRASH_ON;
          beep_idx_d = beep_idx_q + 4'd1;
          restart    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        restart = 1'b1;
      end
    endcase
  end

  // State, phase timer and registered outputs, all taken from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cyc_cnt_q    <= '0;
      ms_cnt_q     <= 16'd0;
      beep_idx_q   <= 4'd0;
      alarm        <= 1'b0;
      busy         <= 1'b0;
      crash_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      beep_idx_q <= beep_idx_d;
      if (restart || (state_d == IDLE)) begin
        cyc_cnt_q <= '0;
        ms_cnt_q  <= 16'd0;
      end else if (cyc_cnt_q == CYC_LAST) begin
        cyc_cnt_q <= '0;
        ms_cnt_q  <= ms_cnt_q + 16'd1;
      end else begin
        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
      end
      alarm        <= ((state_d == EAT_ON) || (state_d == CRASH_ON)) && !mute;
      busy         <= (state_d != IDLE);
      crash_active <= (state_d == CRASH_ON) || (state_d == CRASH_OFF);
    end
  end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: cycle-by-cycle comparison against a
// duration-based behavioural model, plus literal window counts per scenario.
module tb_sound_event_sequencer;

  localparam int CLK_HZ       = 10000;
  localparam int EAT_MS       = 3;
  localparam int CRASH_ON_MS  = 4;
  localparam int CRASH_OFF_MS = 2;
  localparam int CRASH_BEEPS  = 3;
  localparam int TPM          = CLK_HZ / 1000;
  localparam int EAT_T        = EAT_MS * TPM;
  localparam int ON_T         = CRASH_ON_MS * TPM;
  localparam int OFF_T        = CRASH_OFF_MS * TPM;
  localparam int TOTAL        = CRASH_BEEPS * ON_T + (CRASH_BEEPS - 1) * OFF_T;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic eat_evt = 1'b0;
  logic crash_evt = 1'b0;
  logic mute = 1'b0;
  logic alarm, busy, crash_active;

  int n_checks = 0;
  int n_fail = 0;

  sound_event_sequencer #(
    .CLK_HZ(CLK_HZ), .EAT_MS(EAT_MS), .CRASH_ON_MS(CRASH_ON_MS),
    .CRASH_OFF_MS(CRASH_OFF_MS), .CRASH_BEEPS(CRASH_BEEPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .eat_evt(eat_evt), .crash_evt(crash_evt),
    .mute(mute), .alarm(alarm), .busy(busy), .crash_active(crash_active)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 eat beep (cycles remaining), 2 crash (cycles elapsed).
  int m_mode = 0;
  int m_rem = 0;
  int m_t = 0;
  logic m_mute = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_rem  <= 0;
      m_t    <= 0;
      m_mute <= 1'b0;
    end else begin
      m_mute <= mute;
      if (m_mode == 2) begin
        m_t <= m_t + 1;
        if (m_t + 1 == TOTAL) m_mode <= 0;
      end else if (crash_evt) begin
        m_mode <= 2;
        m_t    <= 0;
      end else if (eat_evt) begin
        m_mode <= 1;
        m_rem  <= EAT_T;
      end else if (m_mode == 1) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_mode <= 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model.
  task automatic cyc();
    int e_alarm;
    @(negedge clk);
    e_alarm = ((m_mode == 1) || (m_mode == 2 && (m_t % (ON_T + OFF_T)) < ON_T)) && !m_mute;
    check("alarm", int'(alarm), e_alarm);
    check("busy", int'(busy), int'(m_mode != 0));
    check("crash_active", int'(crash_active), int'(m_mode == 2));
  endtask

  int na, nb, nc;

  initial begin
    repeat (3) cyc();
    check("reset_alarm", int'(alarm), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_crash_active", int'(crash_active), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // 1: single eat beep
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 40; i++) begin
      eat_evt = (i == 0);
      cyc();
      na += int'(alarm); nb += int'(busy); nc += int'(crash_active);
    end
    eat_evt = 1'b0;
    $display("T1 eat beep: alarm=%0d busy=%0d crash=%0d", na, nb, nc);
    check("t1_alarm_cycles", na, 30);
    check("t1_busy_cycles", nb, 30);
    check("t1_crash_cycles", nc, 0);

    // 2: single crash pattern
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 180; i++) begin
      crash_evt = (i == 0);
      cyc();
      na += int'(alarm); nb += int'(busy); nc += int'(crash_active);
    end
    crash_evt = 1'b0;
    $display("T2 crash: alarm=%0d busy=%0d crash=%0d", na, nb, nc);
    check("t2_alarm_cycles", na, 120);
    check("t2_busy_cycles", nb, 160);
    check("t2_crash_cycles", nc, 160);

    // 3: crash preempts eat at edge 12; later events during the pattern ignored
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 200; i++) begin
      eat_evt   = (i == 0) || (i >= 20 && i < 150 && (i % 17) == 0);
      crash_evt = (i == 12) || (i >= 30 && i < 150 && (i % 23) == 0);
      cyc();
      na += int'(alarm); nb += int'(busy); nc += int'(crash_active);
    end
    eat_evt = 1'b0; crash_evt = 1'b0;
    $display("T3 preempt: alarm=%0d busy=%0d crash=%0d", na, nb, nc);
    check("t3_alarm_cycles", na, 132);
    check("t3_busy_cycles", nb, 172);
    check("t3_crash_cycles", nc, 160);

    // 4: retrigger at edge 20 extends beep to cycle 50
    na = 0; nb = 0;
    for (int i = 0; i < 70; i++) begin
      eat_evt = (i == 0) || (i == 20);
      cyc();
      na += int'(alarm); nb += int'(busy);
      if (i == 49) check("t4_alarm_cycle50", int'(alarm), 1);
      if (i == 50) check("t4_alarm_cycle51", int'(alarm), 0);
    end
    eat_evt = 1'b0;
    $display("T4 retrigger: alarm=%0d busy=%0d", na, nb);
    check("t4_alarm_cycles", na, 50);
    check("t4_busy_cycles", nb, 50);

    // 5: simultaneous events with mute held
    mute = 1'b1;
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 180; i++) begin
      eat_evt   = (i == 0);
      crash_evt = (i == 0);
      cyc();
      na += int'(alarm); nb += int'(busy); nc += int'(crash_active);
    end
    eat_evt = 1'b0; crash_evt = 1'b0;
    mute = 1'b0;
    $display("T5 muted both: alarm=%0d busy=%0d crash=%0d", na, nb, nc);
    check("t5_alarm_cycles", na, 0);
    check("t5_busy_cycles", nb, 160);
    check("t5_crash_cycles", nc, 160);
    repeat (3) cyc();

    // 6: asynchronous reset at cycle 70 of a crash pattern, then a clean eat beep
    for (int i = 0; i < 70; i++) begin
      crash_evt = (i == 0);
      cyc();
    end
    crash_evt = 1'b0;
    check("t6_busy_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("T6 async reset: alarm=%0d busy=%0d crash=%0d", alarm, busy, crash_active);
    check("t6_alarm_async", int'(alarm), 0);
    check("t6_busy_async", int'(busy), 0);
    check("t6_crash_async", int'(crash_active), 0);
    cyc();
    rst_n = 1'b1;
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 40; i++) begin
      eat_evt = (i == 0);
      cyc();
      na += int'(alarm); nb += int'(busy); nc += int'(crash_active);
    end
    eat_evt = 1'b0;
    $display("T6 eat after reset: alarm=%0d busy=%0d crash=%0d", na, nb, nc);
    check("t6_alarm_cycles", na, 30);
    check("t6_busy_cycles", nb, 30);
    check("t6_crash_cycles", nc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
